muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the full RV64 M-extension result set (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) over a parametrised datapath width. It replaces single-cycle combinational `*`, `/`, `%` in the execute stage with a start/done multi-cycle engine. The pipeline or control FSM stalls on `busy`. Divide-by-zero and overflow results follow the RISC-V specification exactly.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide engine with a start/busy/done handshake.
// Define MULDIV_WORD_EN to add the 'word' port and the 32-bit W-variant operations.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
`ifdef MULDIV_WORD_EN
    input  logic            word,
`endif
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;

    logic              word_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic              zero_div_in, hi_sel_in, accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, quo_init;

    logic [CNT_W-1:0]  cnt;
    logic              op_div, op_rem, hi_sel, a_neg, b_neg, zdiv, last_iter;
    logic [2*XLEN-1:0] prod, mcand, prod_fix;
    logic [XLEN-1:0]   mplier, dvsr, quo, rem_r, rem_shl;
    logic [XLEN:0]     rem_sub;
    logic [XLEN-1:0]   quo_fix, rem_fix, raw, res_next;
`ifdef MULDIV_WORD_EN
    logic              word_q;
    assign word_in = word;
`else
    assign word_in = 1'b0;
`endif

    assign accept    = (state == IDLE) && start && !kill;
    assign a_sgn_in  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_sgn_in  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign hi_sel_in = !op[2] && (op[1:0] != 2'b00) && !word_in;

    // Operands become sign-tagged magnitudes; a zero divisor parks the raw dividend instead.
    always_comb begin
        a_ext = operand_a;
        b_ext = operand_b;
`ifdef MULDIV_WORD_EN
        if (word_in) begin
            a_ext = {{(XLEN-32){a_sgn_in & operand_a[31]}}, operand_a[31:0]};
            b_ext = {{(XLEN-32){b_sgn_in & operand_b[31]}}, operand_b[31:0]};
        end
`endif
        a_neg_in    = a_sgn_in & a_ext[XLEN-1];
        b_neg_in    = b_sgn_in & b_ext[XLEN-1];
        a_mag       = a_neg_in ? -a_ext : a_ext;
        b_mag       = b_neg_in ? -b_ext : b_ext;
        zero_div_in = op[2] && (b_ext == '0);
        quo_init    = zero_div_in ? a_ext : a_mag;
`ifdef MULDIV_WORD_EN
        if (word_in && !zero_div_in) quo_init = a_mag << (XLEN-32);
`endif
    end

`ifdef MULDIV_WORD_EN
    assign last_iter = (cnt == (word_q ? CNT_W'(31) : CNT_W'(XLEN-1)));
`else
    assign last_iter = (cnt == CNT_W'(XLEN-1));
`endif

    assign rem_shl = {rem_r[XLEN-2:0], quo[XLEN-1]};
    assign rem_sub = {rem_r, quo[XLEN-1]} - {1'b0, dvsr};

    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? -prod : prod;
        quo_fix  = (a_neg ^ b_neg) ? -quo : quo;
        rem_fix  = a_neg ? -rem_r : rem_r;
        if (zdiv)        raw = op_rem ? quo : '1;
        else if (op_div) raw = op_rem ? rem_fix : quo_fix;
        else if (hi_sel) raw = prod_fix[2*XLEN-1:XLEN];
        else             raw = prod_fix[XLEN-1:0];
        res_next = raw;
`ifdef MULDIV_WORD_EN
        if (word_q) res_next = {{(XLEN-32){raw[31]}}, raw[31:0]};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = zero_div_in ? FIX : CALC;
            CALC:    if (kill) state_n = IDLE; else if (last_iter) state_n = FIX;
            FIX:     state_n = kill ? IDLE : DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_div <= 1'b0;
            op_rem <= 1'b0;
            hi_sel <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            zdiv   <= 1'b0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            dvsr   <= '0;
            quo    <= '0;
            rem_r  <= '0;
            result <= '0;
`ifdef MULDIV_WORD_EN
            word_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    op_div <= op[2];
                    op_rem <= op[2] & op[1];
                    hi_sel <= hi_sel_in;
                    a_neg  <= a_neg_in;
                    b_neg  <= b_neg_in;
                    zdiv   <= zero_div_in;
                    prod   <= '0;
                    mcand  <= {{XLEN{1'b0}}, a_mag};
                    mplier <= b_mag;
                    dvsr   <= b_mag;
                    quo    <= quo_init;
                    rem_r  <= '0;
`ifdef MULDIV_WORD_EN
                    word_q <= word_in;
`endif
                end
                CALC: if (!kill) begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        rem_r <= rem_sub[XLEN] ? rem_shl : rem_sub[XLEN-1:0];
                        quo   <= {quo[XLEN-2:0], ~rem_sub[XLEN]};
                    end else begin
                        prod   <= prod + (mplier[0] ? mcand : '0);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: if (!kill) result <= res_next;
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RISC-V corner cases, control flow, and random ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
`ifdef MULDIV_WORD_EN
    logic            word;
`endif
    logic [XLEN-1:0] operand_a, operand_b;
    logic            kill;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int              total = 0;
    int              bad = 0;
    logic [63:0]     last_exp = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
`ifdef MULDIV_WORD_EN
        .word(word),
`endif
        .operand_a(operand_a),
        .operand_b(operand_b),
        .kill(kill),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                              input logic [63:0] b, input logic w);
        longint            sa64, sb64;
        int                sa32, sb32;
        logic signed [127:0] sa, sb, ubs;
        logic [127:0]      p;
        logic [63:0]       r;
        logic [31:0]       r32;
        sa64 = a;
        sb64 = b;
        sa   = sa64;
        sb   = sb64;
        ubs  = $signed({64'd0, b});
        r    = '0;
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            case (o)
                3'b100: if (b[31:0] == 0) r32 = '1;
                        else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
                        else r32 = sa32 / sb32;
                3'b101: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
                3'b110: if (b[31:0] == 0) r32 = a[31:0];
                        else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = '0;
                        else r32 = sa32 % sb32;
                3'b111: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
                default: r32 = a[31:0] * b[31:0];
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (o)
            3'b000: r = a * b;
            3'b001: begin p = sa * sb;  r = p[127:64]; end
            3'b010: begin p = sa * ubs; r = p[127:64]; end
            3'b011: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            3'b100: if (b == 0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = sa64 / sb64;
            3'b101: if (b == 0) r = '1; else r = a / b;
            3'b110: if (b == 0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                    else r = sa64 % sb64;
            default: if (b == 0) r = a; else r = a % b;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {32'd0, 32'($urandom_range(0, 100))};
            4:       return -{32'd0, 32'($urandom_range(1, 100))};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one op and watches it; poke_at re-raises start mid-op, kill_at pulses kill.
    task automatic applyStimulus(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                 input logic w, input int poke_at, input int kill_at,
                                 output logic [63:0] res, output int lat, output logic ctl_ok);
        lat    = -1;
        ctl_ok = 1'b1;
        res    = '0;
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
`ifdef MULDIV_WORD_EN
        word = w;
`else
        if (w) ctl_ok = 1'b0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b1) ctl_ok = 1'b0;
        for (int k = 1; k <= XLEN + 20; k++) begin
            start = (k == poke_at);
            kill  = (k == kill_at);
            if (k == poke_at) begin
                op        = ~o;
                operand_a = b;
                operand_b = a;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k + 1;
                res = result;
                if (busy !== 1'b0) ctl_ok = 1'b0;
                break;
            end
            if (kill_at == 0 && busy !== 1'b1) ctl_ok = 1'b0;
        end
        start = 1'b0;
        kill  = 1'b0;
        if (lat < 0) res = result;
        else begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || result !== res) ctl_ok = 1'b0;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [63:0] a,
                             input logic [63:0] b, input logic w, input int poke_at);
        logic [63:0] res, exp_res;
        int          lat, exp_lat;
        logic        ok;
        exp_res = ref_model(o, a, b, w);
        if (o[2] && (w ? (b[31:0] == 0) : (b == 0))) exp_lat = 2;
        else exp_lat = w ? 34 : XLEN + 2;
        applyStimulus(o, a, b, w, poke_at, 0, res, lat, ok);
        checkOutput({tag, "_res"}, res, exp_res);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_ctl"}, {63'd0, ok}, 64'd1);
        last_exp = exp_res;
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        logic        ok;
        logic [2:0]  ro;

        $display("[TB] muldiv_unit bench start");
        rst = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        op = 3'b000;
        operand_a = '0;
        operand_b = '0;
`ifdef MULDIV_WORD_EN
        word = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_check("mul_7xm3", 3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
        checkOutput("mul_7xm3_const", last_exp, 64'hFFFF_FFFF_FFFF_FFEB);
        run_check("mulhu_ones", 3'b011, '1, '1, 1'b0, 0);
        run_check("mulh_m1m1", 3'b001, '1, '1, 1'b0, 0);
        run_check("mulhsu_m1x2", 3'b010, '1, 64'd2, 1'b0, 0);
        run_check("div_m7_2", 3'b100, -64'd7, 64'd2, 1'b0, 0);
        run_check("rem_m7_2", 3'b110, -64'd7, 64'd2, 1'b0, 0);
        run_check("div_by0", 3'b100, 64'd5, 64'd0, 1'b0, 0);
        run_check("remu_by0", 3'b111, 64'd5, 64'd0, 1'b0, 0);
        run_check("div_ovf", 3'b100, 64'h8000_0000_0000_0000, '1, 1'b0, 0);
        run_check("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, '1, 1'b0, 0);
        run_check("div_restart", 3'b100, 64'd1000, 64'd7, 1'b0, 10);

        applyStimulus(3'b100, 64'd123456789, 64'd11, 1'b0, 0, 30, res, lat, ok);
        checkOutput("kill_no_done", 64'(lat), '1);
        checkOutput("kill_result", res, last_exp);
        checkOutput("kill_busy", {63'd0, busy}, 64'd0);
        run_check("post_kill", 3'b101, 64'd123456789, 64'd11, 1'b0, 0);

        @(negedge clk);
        start = 1'b1;
        kill  = 1'b1;
        op    = 3'b000;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        checkOutput("kill_idle_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("kill_idle_done", {63'd0, done}, 64'd0);

        @(negedge clk);
        start = 1'b1;
        op = 3'b000;
        operand_a = 64'd99;
        operand_b = 64'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_mid_done", {63'd0, done}, 64'd0);
        checkOutput("rst_mid_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_check("post_rst", 3'b001, 64'h7FFF_0000_1234_5678, 64'hFFFF_FFFF_0000_0001, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            run_check("rand", ro, pick_val(), pick_val(), 1'b0, 0);
        end

`ifdef MULDIV_WORD_EN
        run_check("divw_ovf", 3'b100, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 7));
            run_check("rand_w", ro, pick_val(), pick_val(), 1'b1, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
